spad_row_scheduler: RTL and testbench
=====================================

Name: spad_row_scheduler

Overview:
- Sequences one scratchpad_mem instance through a convolution pass.
- Phases of a pass:
  - Initial fill: writes K input rows from the feature-fetch stream into FIFO lines 0..K-1.
  - Read: streams one output row of K-line feature columns to the PE array.
  - Drain: waits for the line shift buffers to copy line i+1 into line i.
  - Refill: writes one new input row into the top line.
- Sits between the feature-load DMA stream and scratchpad_mem. It owns all scratchpad control pins.

Parameters:
- FEATURE_WIDTH, `FEATURE_WIDTH (16): bits per feature.
- DATA_BUS_WIDTH, `DATA_BUS_WIDTH (128): fetch word width.
- KERNEL_SIZE, `KERNEL_SIZE (5): number of physical FIFO lines.
- DRAIN_CYCLES, 4: idle cycles after the last read of a row, covering the shift-buffer write latency.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cfg_valid  in  1  start request; sampled in IDLE only
- cfg_ready  out  1  high in IDLE
- cfg_kn_mode  in  2  KERNEL_SIZE_5/3/1_MODE encoding
- cfg_row_words  in  8  fetch words per input row
- cfg_out_rows  in  10  output rows in the pass
- fetch_valid  in  1  fetch word valid
- fetch_data  in  DATA_BUS_WIDTH  fetch word
- fetch_ready  out  1  fetch word accepted this cycle
- out_ready  in  1  PE array can take a column
- out_valid  out  1  scratchpad data_out valid this cycle
- out_last  out  1  with out_valid: last column of the current output row
- spad_i_data  out  DATA_BUS_WIDTH  to scratchpad i_data
- spad_wr_en  out  1  to scratchpad wr_en
- spad_wr_line  out  4  to scratchpad wr_mem_line
- spad_rd_en  out  1  to scratchpad rd_en
- spad_rd_line  out  4  to scratchpad rd_mem_line; constant 0
- spad_kn_mode  out  2  to scratchpad kn_size_mode; latched config
- spad_group_empty  in  1  from scratchpad
- spad_group_full  in  1  from scratchpad
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of pass

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: all outputs 0 except cfg_ready=1; state IDLE; all counters 0; spad_kn_mode=0. Reset mid-pass aborts to IDLE without a done pulse. The scratchpad shares rst, so its contents are also discarded.
- Config latch: on cfg_valid&&cfg_ready, latch all cfg_* fields. K = 5/3/1 by mode; any unknown mode encoding means K=5.
- Degenerate config: cfg_row_words==0 or cfg_out_rows==0 goes IDLE -> DONE directly, with no fetch and no read activity.
- States: IDLE, FILL, READ, DRAIN, REFILL, DONE.
- FILL:
  - fetch_ready = !spad_group_full.
  - Each accepted word: spad_wr_en=1, spad_i_data=fetch_data, spad_wr_line=line_cnt (all combinational), then word_cnt++.
  - When word_cnt reaches row_words-1 on an accept: word_cnt wraps to 0 and line_cnt++.
  - After line K-1 completes: line_cnt=0, go to READ.
- READ:
  - spad_rd_en = out_ready && !spad_group_empty.
  - Each rd_en increments feat_cnt (3 bits, 8 features per word). On feat_cnt wrap, word_cnt++.
  - The last read of the row is feat_cnt==7 && word_cnt==row_words-1.
  - After the last read: row_cnt++. If row_cnt reaches out_rows, go to DONE; otherwise go to DRAIN.
- out_valid / out_last: out_valid is spad_rd_en registered one cycle (FIFO read latency 1). out_last is the registered last-read flag.
- DRAIN: count DRAIN_CYCLES cycles with no rd_en and no wr_en, then go to REFILL. For K=1 skip DRAIN and go straight to REFILL.
- REFILL:
  - Identical to FILL but for one row only, written to line K-1. With K=1 that is line 0.
  - Fetch has priority over the buffer in the scratchpad input switch, so scheduling writes after DRAIN avoids collisions.
  - When the row completes, go to READ.
- DONE: done=1 for one cycle, then IDLE.
- Flow control:
  - spad_wr_en never asserts while spad_group_full=1.
  - spad_rd_en never asserts while spad_group_empty=1.
  - fetch_ready=0 outside FILL/REFILL.
  - Stalls hold all counters.
- Concurrency: out_ready low during READ only stalls the read; it never changes state. fetch_valid outside FILL/REFILL is ignored and not consumed.
- Counter widths: word_cnt 8 bits, line_cnt 3 bits, feat_cnt 3 bits, row_cnt 10 bits. No counter can overflow for legal config values.

Decomposition:
- Shared package (network_para.vh):
  - KERNEL_SIZE_5/3/1_MODE encodings.
  - State encoding localparams.
  - A function mapping mode to K.
- One natural sub-module, spad_rw_counter: the feat/word/line counter nest with wrap flags, instantiated twice (write side, read side).

Test Plan:
- K=5, row_words=2, out_rows=1, fetch always valid, out_ready=1 -> 10 writes with spad_wr_line 0,0,1,1,2,2,3,3,4,4; then 16 rd_en cycles; out_valid trails rd_en by 1; out_last on the 16th out_valid; one done pulse; 0 drain cycles.
- K=3, row_words=1, out_rows=3 -> 3 fill writes to lines 0..2; 3×8 reads; 2 DRAIN windows of 4 cycles each; 2 refill writes, both on line 2; done after the third row.
- K=1, row_words=1, out_rows=2 -> writes on line 0 only; no DRAIN state entered; 16 total reads.
- Backpressure:
  - Toggle out_ready every cycle -> rd_en only when out_ready=1; 8 reads per word preserved.
  - spad_group_full=1 during FILL -> fetch_ready=0 and no wr_en until it drops.
- cfg_out_rows=0 -> done pulse 2 cycles after accept; no fetch_ready or rd_en ever asserted.
- rst asserted mid-READ, asynchronously between clock edges -> all outputs reset immediately; cfg_ready=1; no done pulse; a new pass then completes normally.

Source files
------------

// File: rtl/spad_row_scheduler_pkg.sv
// Shared encodings and helpers for the scratchpad row scheduler.
package spad_row_scheduler_pkg;

  localparam int FEATURE_WIDTH  = 16;
  localparam int DATA_BUS_WIDTH = 128;
  localparam int KERNEL_SIZE    = 5;
  localparam int DRAIN_CYCLES   = 4;

  localparam logic [1:0] KERNEL_SIZE_5_MODE = 2'd0;
  localparam logic [1:0] KERNEL_SIZE_3_MODE = 2'd1;
  localparam logic [1:0] KERNEL_SIZE_1_MODE = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_READ   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_REFILL = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Unknown encodings fall back to the largest kernel.
  function automatic logic [2:0] kn_mode_to_k(input logic [1:0] mode);
    case (mode)
      KERNEL_SIZE_3_MODE: kn_mode_to_k = 3'd3;
      KERNEL_SIZE_1_MODE: kn_mode_to_k = 3'd1;
      default:            kn_mode_to_k = 3'd5;
    endcase
  endfunction

endpackage

// File: rtl/spad_row_scheduler_rw_counter.sv
// Feature/word/line counter nest; the feature level can be bypassed for
// word-granular writes and the line level frozen for single-line traffic.
module spad_rw_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       step,
  input  logic       feat_en,
  input  logic       line_en,
  input  logic [7:0] row_words,
  input  logic [2:0] line_max,
  output logic [2:0] line_cnt,
  output logic       word_wrap,
  output logic       line_wrap
);

  logic [2:0] feat_cnt;
  logic [7:0] word_cnt;
  logic       feat_wrap;

  assign feat_wrap = !feat_en || (feat_cnt == 3'd7);
  assign word_wrap = feat_wrap && (word_cnt == row_words - 8'd1);
  assign line_wrap = word_wrap && (line_cnt == line_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feat_cnt <= 3'd0;
      word_cnt <= 8'd0;
      line_cnt <= 3'd0;
    end else if (clr) begin
      feat_cnt <= 3'd0;
      word_cnt <= 8'd0;
      line_cnt <= 3'd0;
    end else if (step) begin
      if (feat_en) feat_cnt <= feat_cnt + 3'd1;
      if (feat_wrap) begin
        if (word_wrap) begin
          word_cnt <= 8'd0;
          if (line_en) line_cnt <= line_wrap ? 3'd0 : line_cnt + 3'd1;
        end else begin
          word_cnt <= word_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/spad_row_scheduler.sv
// Sequences one scratchpad_mem through a convolution pass: fill K lines,
// then per output row read, drain the shift buffers and refill the top line.
module spad_row_scheduler
  import spad_row_scheduler_pkg::*;
#(
  parameter int DATA_BUS_WIDTH_P = DATA_BUS_WIDTH,
  parameter int DRAIN_CYCLES_P   = DRAIN_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [1:0]                  cfg_kn_mode,
  input  logic [7:0]                  cfg_row_words,
  input  logic [9:0]                  cfg_out_rows,
  input  logic                        fetch_valid,
  input  logic [DATA_BUS_WIDTH_P-1:0] fetch_data,
  output logic                        fetch_ready,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic                        out_last,
  output logic [DATA_BUS_WIDTH_P-1:0] spad_i_data,
  output logic                        spad_wr_en,
  output logic [3:0]                  spad_wr_line,
  output logic                        spad_rd_en,
  output logic [3:0]                  spad_rd_line,
  output logic [1:0]                  spad_kn_mode,
  input  logic                        spad_group_empty,
  input  logic                        spad_group_full,
  output logic                        busy,
  output logic                        done
);

  state_t     state;
  logic [2:0] k_lines;
  logic [2:0] line_max;
  logic [7:0] row_words;
  logic [9:0] out_rows;
  logic [9:0] row_cnt;
  logic [7:0] drain_cnt;
  logic       cnt_clr;
  logic       fill_active;
  logic [2:0] wr_line_cnt;
  logic       wr_word_wrap;
  logic       wr_line_wrap;
  logic [2:0] rd_line_cnt;
  logic       rd_word_wrap;
  logic       unused_rd_line_wrap;

  // Handshakes: a fetch word transfers on fetch_valid && fetch_ready, a config
  // on cfg_valid && cfg_ready; a column is read only when out_ready is high
  // and appears on out_valid one cycle later (FIFO read latency).
  assign cfg_ready    = (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);
  assign fill_active  = (state == ST_FILL) || (state == ST_REFILL);
  assign fetch_ready  = fill_active && !spad_group_full;
  assign spad_wr_en   = fetch_ready && fetch_valid;
  assign spad_i_data  = fetch_data;
  assign line_max     = k_lines - 3'd1;
  assign spad_wr_line = {1'b0, (state == ST_REFILL) ? line_max : wr_line_cnt};
  assign spad_rd_en   = (state == ST_READ) && out_ready && !spad_group_empty;
  assign spad_rd_line = {1'b0, rd_line_cnt};
  assign cnt_clr      = (state == ST_IDLE) && cfg_valid;

  spad_rw_counter u_wr_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .step      (spad_wr_en),
    .feat_en   (1'b0),
    .line_en   (state == ST_FILL),
    .row_words (row_words),
    .line_max  (line_max),
    .line_cnt  (wr_line_cnt),
    .word_wrap (wr_word_wrap),
    .line_wrap (wr_line_wrap)
  );

  // Read side never advances lines: the shift buffers bring data to line 0.
  spad_rw_counter u_rd_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .step      (spad_rd_en),
    .feat_en   (1'b1),
    .line_en   (1'b0),
    .row_words (row_words),
    .line_max  (3'd0),
    .line_cnt  (rd_line_cnt),
    .word_wrap (rd_word_wrap),
    .line_wrap (unused_rd_line_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      k_lines      <= 3'd0;
      row_words    <= 8'd0;
      out_rows     <= 10'd0;
      spad_kn_mode <= 2'd0;
      row_cnt      <= 10'd0;
      drain_cnt    <= 8'd0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      done         <= 1'b0;
    end else begin
      out_valid <= spad_rd_en;
      out_last  <= spad_rd_en && rd_word_wrap;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_valid) begin
            k_lines      <= kn_mode_to_k(cfg_kn_mode);
            row_words    <= cfg_row_words;
            out_rows     <= cfg_out_rows;
            spad_kn_mode <= cfg_kn_mode;
            row_cnt      <= 10'd0;
            drain_cnt    <= 8'd0;
            if (cfg_row_words == 8'd0 || cfg_out_rows == 10'd0) state <= ST_DONE;
            else state <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (spad_wr_en && wr_line_wrap) state <= ST_READ;
        end
        ST_READ: begin
          if (spad_rd_en && rd_word_wrap) begin
            row_cnt <= row_cnt + 10'd1;
            if (row_cnt + 10'd1 == out_rows) state <= ST_DONE;
            else if (k_lines == 3'd1) state <= ST_REFILL;
            else begin
              drain_cnt <= 8'd0;
              state     <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 8'(DRAIN_CYCLES_P - 1)) begin
            drain_cnt <= 8'd0;
            state     <= ST_REFILL;
          end else begin
            drain_cnt <= drain_cnt + 8'd1;
          end
        end
        ST_REFILL: begin
          if (spad_wr_en && wr_word_wrap) state <= ST_READ;
        end
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spad_row_scheduler.sv
// Directed self-checking bench for spad_row_scheduler.
module tb_spad_row_scheduler;
  import spad_row_scheduler_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [1:0]   cfg_kn_mode;
  logic [7:0]   cfg_row_words;
  logic [9:0]   cfg_out_rows;
  logic         fetch_valid;
  logic [127:0] fetch_data;
  logic         fetch_ready;
  logic         out_ready;
  logic         out_valid;
  logic         out_last;
  logic [127:0] spad_i_data;
  logic         spad_wr_en;
  logic [3:0]   spad_wr_line;
  logic         spad_rd_en;
  logic [3:0]   spad_rd_line;
  logic [1:0]   spad_kn_mode;
  logic         spad_group_empty;
  logic         spad_group_full;
  logic         busy;
  logic         done;

  spad_row_scheduler dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_kn_mode(cfg_kn_mode), .cfg_row_words(cfg_row_words), .cfg_out_rows(cfg_out_rows),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_ready(fetch_ready),
    .out_ready(out_ready), .out_valid(out_valid), .out_last(out_last),
    .spad_i_data(spad_i_data), .spad_wr_en(spad_wr_en), .spad_wr_line(spad_wr_line),
    .spad_rd_en(spad_rd_en), .spad_rd_line(spad_rd_line), .spad_kn_mode(spad_kn_mode),
    .spad_group_empty(spad_group_empty), .spad_group_full(spad_group_full),
    .busy(busy), .done(done)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // background drivers
  logic toggle_rdy = 1'b0;
  always @(posedge clk) begin
    #1;
    fetch_data = fetch_data + 128'd1;
    if (toggle_rdy) out_ready = ~out_ready;
  end

  // monitor / scoreboard
  logic [3:0] wr_q[$];
  logic [3:0] exp_q[$];
  int gap_q[$];
  int wr_cnt, rd_cnt, ov_cnt, last_cnt, last_at, done_cnt, fr_cnt, viol, lag_err, gap_len;
  bit in_gap, prev_rd;

  always @(negedge clk) begin
    if (rst) begin
      prev_rd = 1'b0;
      in_gap  = 1'b0;
    end else begin
      if (out_valid !== prev_rd) lag_err++;
      prev_rd = spad_rd_en;
      if (fetch_ready) fr_cnt++;
      if (spad_wr_en) begin
        wr_cnt++;
        wr_q.push_back(spad_wr_line);
        if (in_gap) begin
          gap_q.push_back(gap_len);
          in_gap = 1'b0;
        end
        if (spad_i_data !== fetch_data || !fetch_valid) viol++;
      end
      if (spad_rd_en) begin
        rd_cnt++;
        in_gap  = 1'b1;
        gap_len = 0;
        if (spad_rd_line !== 4'd0) viol++;
      end else if (!spad_wr_en && in_gap) begin
        gap_len++;
      end
      if (out_valid) begin
        ov_cnt++;
        if (out_last) begin
          last_cnt++;
          last_at = ov_cnt;
        end
      end
      if (out_last && !out_valid) viol++;
      if (done) done_cnt++;
      if (!busy) in_gap = 1'b0;
      if (spad_wr_en && spad_group_full) viol++;
      if (fetch_ready && spad_group_full) viol++;
      if (spad_rd_en && (spad_group_empty || !out_ready)) viol++;
    end
  end

  task automatic clear_mon();
    wr_q.delete();
    exp_q.delete();
    gap_q.delete();
    wr_cnt = 0; rd_cnt = 0; ov_cnt = 0; last_cnt = 0; last_at = 0;
    done_cnt = 0; fr_cnt = 0; viol = 0; lag_err = 0; gap_len = 0;
  endtask

  // driver tasks
  task automatic start_pass(input logic [1:0] mode, input logic [7:0] rw, input logic [9:0] rows);
    @(posedge clk); #1;
    cfg_kn_mode   = mode;
    cfg_row_words = rw;
    cfg_out_rows  = rows;
    cfg_valid     = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < budget);
    check_eq(tag, {31'd0, done === 1'b1}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_lines(input string tag);
    check_eq({tag, "_wr_count"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check_eq($sformatf("%s_line%0d", tag, i), {28'd0, wr_q[i]}, {28'd0, exp_q[i]});
  endtask

  task automatic check_common(input string tag, input int reads, input int rows);
    check_eq({tag, "_rd"}, rd_cnt, reads);
    check_eq({tag, "_ov"}, ov_cnt, reads);
    check_eq({tag, "_last_cnt"}, last_cnt, rows);
    check_eq({tag, "_last_at"}, last_at, reads);
    check_eq({tag, "_done_cnt"}, done_cnt, 1);
    check_eq({tag, "_lag"}, lag_err, 0);
    check_eq({tag, "_viol"}, viol, 0);
  endtask

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0; cfg_kn_mode = 2'd0; cfg_row_words = 8'd0; cfg_out_rows = 10'd0;
    fetch_valid = 1'b1; fetch_data = 128'd0; out_ready = 1'b1;
    spad_group_empty = 1'b0; spad_group_full = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);
    check_eq("rst_cfg_ready", {31'd0, cfg_ready}, 1);
    check_eq("rst_outputs", {24'd0, busy, done, out_valid, out_last, fetch_ready,
                             spad_wr_en, spad_rd_en, 1'b0}, 0);
    check_eq("rst_kn_mode", {30'd0, spad_kn_mode}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // K=5, 2 words/row, 1 row
    clear_mon();
    start_pass(KERNEL_SIZE_5_MODE, 8'd2, 10'd1);
    wait_done("k5_done", 200);
    exp_q = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4};
    check_lines("k5");
    check_common("k5", 16, 1);
    check_eq("k5_gaps", gap_q.size(), 0);

    // K=3, 1 word/row, 3 rows: two drain windows of 4 cycles
    clear_mon();
    start_pass(KERNEL_SIZE_3_MODE, 8'd1, 10'd3);
    wait_done("k3_done", 300);
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd2};
    check_lines("k3");
    check_common("k3", 24, 3);
    check_eq("k3_gap_n", gap_q.size(), 2);
    for (int i = 0; i < gap_q.size(); i++) check_eq($sformatf("k3_gap%0d", i), gap_q[i], 4);
    check_eq("k3_kn_mode", {30'd0, spad_kn_mode}, 1);

    // K=1, 1 word/row, 2 rows: no drain
    clear_mon();
    start_pass(KERNEL_SIZE_1_MODE, 8'd1, 10'd2);
    wait_done("k1_done", 200);
    exp_q = '{4'd0, 4'd0};
    check_lines("k1");
    check_common("k1", 16, 2);
    check_eq("k1_gap_n", gap_q.size(), 1);
    if (gap_q.size() > 0) check_eq("k1_gap0", gap_q[0], 0);
    check_eq("k1_kn_mode", {30'd0, spad_kn_mode}, 2);

    // unknown mode behaves as K=5
    clear_mon();
    start_pass(2'd3, 8'd1, 10'd1);
    wait_done("mode3_done", 200);
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    check_lines("mode3");
    check_common("mode3", 8, 1);

    // out_ready toggling every cycle
    clear_mon();
    toggle_rdy = 1'b1;
    start_pass(KERNEL_SIZE_1_MODE, 8'd1, 10'd1);
    wait_done("bp_rdy_done", 200);
    toggle_rdy = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    check_common("bp_rdy", 8, 1);

    // group_full held during fill
    clear_mon();
    spad_group_full = 1'b1;
    start_pass(KERNEL_SIZE_3_MODE, 8'd1, 10'd1);
    repeat (8) @(negedge clk);
    check_eq("full_hold_wr", wr_cnt, 0);
    check_eq("full_hold_fr", fr_cnt, 0);
    check_eq("full_hold_busy", {31'd0, busy}, 1);
    @(posedge clk); #1 spad_group_full = 1'b0;
    wait_done("full_done", 200);
    exp_q = '{4'd0, 4'd1, 4'd2};
    check_lines("full");
    check_common("full", 8, 1);

    // zero output rows: done two cycles after accept, nothing else
    clear_mon();
    start_pass(KERNEL_SIZE_5_MODE, 8'd4, 10'd0);
    @(negedge clk);
    check_eq("zero_rows_c1_done", {31'd0, done}, 0);
    check_eq("zero_rows_c1_busy", {31'd0, busy}, 1);
    @(negedge clk);
    check_eq("zero_rows_c2_done", {31'd0, done}, 1);
    repeat (3) @(negedge clk);
    check_eq("zero_rows_fr", fr_cnt, 0);
    check_eq("zero_rows_rd", rd_cnt, 0);
    check_eq("zero_rows_done_cnt", done_cnt, 1);

    // zero row words
    clear_mon();
    start_pass(KERNEL_SIZE_3_MODE, 8'd0, 10'd2);
    wait_done("zero_words_done", 10);
    check_eq("zero_words_activity", fr_cnt + rd_cnt + wr_cnt, 0);

    // asynchronous reset in the middle of READ
    clear_mon();
    start_pass(KERNEL_SIZE_5_MODE, 8'd2, 10'd2);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (spad_rd_en !== 1'b1 && n < 200);
      check_eq("arst_reach_read", {31'd0, spad_rd_en === 1'b1}, 1);
    end
    #2 rst = 1'b1;
    #1;
    check_eq("arst_cfg_ready", {31'd0, cfg_ready}, 1);
    check_eq("arst_outputs", {25'd0, busy, done, out_valid, out_last, fetch_ready,
                              spad_wr_en, spad_rd_en}, 0);
    check_eq("arst_kn_mode", {30'd0, spad_kn_mode}, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("arst_no_done", done_cnt, 0);
    clear_mon();
    start_pass(KERNEL_SIZE_3_MODE, 8'd1, 10'd1);
    wait_done("arst_restart_done", 200);
    exp_q = '{4'd0, 4'd1, 4'd2};
    check_lines("arst_restart");
    check_common("arst_restart", 8, 1);

    // report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=timeout expected=finish");
    $fatal(1, "global timeout");
  end

endmodule
